// File: rtl/key_pkg.sv
// Shared constants and types for the key scanner: key indices, mode codes,
// the repeat-FSM state type and the debug bundle exposed by key_scan.
package key_pkg;

    // Bit positions inside the raw key bus
    localparam int KEY_MODE = 0;
    localparam int KEY_FRE  = 1;
    localparam int KEY_PHA  = 2;
    localparam int NUM_KEYS = 3;

    // Waveform mode codes, stepped in this order by the mode key
    localparam logic [1:0] MODE_0 = 2'b00;
    localparam logic [1:0] MODE_1 = 2'b01;
    localparam logic [1:0] MODE_2 = 2'b10;
    localparam logic [1:0] MODE_3 = 2'b11;

    // Hold-to-repeat state of a freq/phase key
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } rpt_state_e;

    // Internal state made visible for checkers; not used by the DDS datapath
    typedef struct packed {
        logic [2:0] stb;        // debounced level per key, 1 = released
        logic [2:0] press;      // one-cycle press event per key
        logic [2:0] rel;        // one-cycle release event per key
        rpt_state_e fre_state;  // freq key repeat FSM
        rpt_state_e pha_state;  // phase key repeat FSM
    } key_dbg_t;

    // Counter width for a count of n cycles; never below one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Next mode code, wrapping 11 -> 00
    function automatic logic [1:0] next_mode(input logic [1:0] m);
        return m + 2'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key front end: two-flop synchroniser followed by a counter debounce.
// The accepted level only moves after DEB_CYC consecutive disagreeing samples;
// press_o / release_o are one-cycle pulses in the cycle the level flips.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYC = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,      // raw, active-low, asynchronous
    output logic stb_o,      // accepted level, 1 = released
    output logic press_o,    // one-cycle pulse on 1 -> 0 of stb
    output logic release_o   // one-cycle pulse on 0 -> 1 of stb
);

    localparam int unsigned   CW       = cnt_width(DEB_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stb_q,     stb_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          press_q,   press_d;
    logic          release_q, release_d;

    // Synchronise the raw pin; both stages idle at "released"
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreements; accept the new level on the last one
    always_comb begin
        stb_d     = stb_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q != stb_q) begin
            if (cnt_q == CNT_LAST) begin
                stb_d     = sync2_q;
                press_d   = ~sync2_q;
                release_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state and event registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stb_q     <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            stb_q     <= stb_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign stb_o     = stb_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_scan.sv
// Key scanner for the DDS generator: debounces the mode, freq and phase keys,
// steps the 2-bit mode code on each mode press and produces one-cycle
// fre_adjust / pha_adjust pulses with hold-to-repeat.
// Event semantics: every press/release/adjust signal is a single-cycle pulse
// with no handshake; consumers must sample it on the cycle it is high.
module key_scan
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYC   = 1_000_000,
    parameter int unsigned HOLD_CYC  = 25_000_000,
    parameter int unsigned RPT_CYC   = 5_000_000,
    parameter logic [1:0]  MODE_INIT = MODE_1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [2:0] key_in,
    output logic [1:0] mode_key,
    output logic       fre_adjust,
    output logic       pha_adjust,
    output key_dbg_t   dbg_o
);

    localparam int unsigned   TMR_MAX   = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
    localparam int unsigned   TW        = cnt_width(TMR_MAX);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] RPT_LAST  = TW'(RPT_CYC - 1);

    logic [2:0] key_stb;
    logic [2:0] key_press;
    logic [2:0] key_release;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_deb
        key_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk_i     (sys_clk),
            .rst_i     (sys_rst),
            .key_i     (key_in[k]),
            .stb_o     (key_stb[k]),
            .press_o   (key_press[k]),
            .release_o (key_release[k])
        );
    end

    // ---------------------------------------------------------------- mode
    logic [1:0] mode_q, mode_d;

    // Advance the mode code once per debounced mode press
    always_comb begin
        mode_d = mode_q;
        if (key_press[KEY_MODE]) begin
            mode_d = next_mode(mode_q);
        end
    end

    // Mode code register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_q <= MODE_INIT;
        end else begin
            mode_q <= mode_d;
        end
    end

    // ------------------------------------------------------ repeat FSMs
    // Index 0 serves the freq key, index 1 the phase key.
    rpt_state_e rpt_state [2];
    logic [1:0] rpt_pulse;

    for (genvar r = 0; r < 2; r++) begin : g_rpt
        rpt_state_e    state_q, state_d;
        logic [TW-1:0] tmr_q,   tmr_d;
        logic          pulse_q, pulse_d;
        logic          press_w;
        logic          release_w;

        assign press_w   = key_press[KEY_FRE + r];
        assign release_w = key_release[KEY_FRE + r];

        // Next state: pulse on press, after the hold delay, then every repeat
        // period; a release wins over a timer expiry in the same cycle
        always_comb begin
            state_d = state_q;
            tmr_d   = tmr_q;
            pulse_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (press_w) begin
                        pulse_d = 1'b1;
                        state_d = HOLD;
                        tmr_d   = '0;
                    end
                end
                HOLD: begin
                    if (release_w) begin
                        state_d = IDLE;
                        tmr_d   = '0;
                    end else if (tmr_q == HOLD_LAST) begin
                        pulse_d = 1'b1;
                        state_d = RPT;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                RPT: begin
                    if (release_w) begin
                        state_d = IDLE;
                        tmr_d   = '0;
                    end else if (tmr_q == RPT_LAST) begin
                        pulse_d = 1'b1;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end
            endcase
        end

        // Repeat FSM state, timer and registered pulse
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                state_q <= IDLE;
                tmr_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                tmr_q   <= tmr_d;
                pulse_q <= pulse_d;
            end
        end

        assign rpt_state[r] = state_q;
        assign rpt_pulse[r] = pulse_q;
    end

    // ------------------------------------------------------------ outputs
    assign mode_key   = mode_q;
    assign fre_adjust = rpt_pulse[0];
    assign pha_adjust = rpt_pulse[1];

    assign dbg_o.stb       = key_stb;
    assign dbg_o.press     = key_press;
    assign dbg_o.rel       = key_release;
    assign dbg_o.fre_state = rpt_state[0];
    assign dbg_o.pha_state = rpt_state[1];

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan with short debounce/hold/repeat times. A behavioural model
// (sample-window debounce and time-since-press pulse schedule) is checked every
// cycle; table vectors and hand-written sequences check exact counts and cycles.
`timescale 1ns/1ps
module tb_key_scan;
    import key_pkg::*;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int RPT  = 5;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [2:0] key_in  = 3'b111;
    logic [1:0] mode_key;
    logic       fre_adjust;
    logic       pha_adjust;
    key_dbg_t   dbg;

    key_scan #(
        .DEB_CYC   (DEB),
        .HOLD_CYC  (HOLD),
        .RPT_CYC   (RPT),
        .MODE_INIT (2'b01)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_in),
        .mode_key   (mode_key),
        .fre_adjust (fre_adjust),
        .pha_adjust (pha_adjust),
        .dbg_o      (dbg)
    );

    // ------------------------------------------------ clock
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------ scoreboard counters
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------ reference model
    logic [2:0] m_hist[$];   // raw samples, newest first
    logic [2:0] m_stb;
    logic [2:0] m_press_ev;
    logic [2:0] m_rel_ev;
    int         m_mode;
    bit         m_active [2];
    int         m_start  [2];
    logic       m_pulse  [2];
    int         m_edge;

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < DEB + 1; i++) m_hist.push_front(3'b111);
        m_stb      = 3'b111;
        m_press_ev = 3'b000;
        m_rel_ev   = 3'b000;
        m_mode     = 1;
        m_edge     = 0;
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_start[i]  = 0;
            m_pulse[i]  = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [2:0] raw);
        int d;
        bit all_diff;
        m_edge++;
        // outputs react one edge after the debounced event
        if (m_press_ev[0]) m_mode = (m_mode + 1) % 4;
        for (int i = 0; i < 2; i++) begin
            m_pulse[i] = 1'b0;
            if (m_rel_ev[i+1]) begin
                m_active[i] = 1'b0;
            end else if (m_press_ev[i+1]) begin
                m_active[i] = 1'b1;
                m_start[i]  = m_edge;
                m_pulse[i]  = 1'b1;
            end else if (m_active[i]) begin
                d = m_edge - m_start[i];
                if (d == HOLD || (d > HOLD && (d - HOLD) % RPT == 0)) m_pulse[i] = 1'b1;
            end
        end
        // accepted level flips once the last DEB synchronised samples all disagree
        for (int k = 0; k < 3; k++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= DEB; j++) begin
                if (m_hist[j][k] == m_stb[k]) all_diff = 1'b0;
            end
            m_press_ev[k] = all_diff & m_stb[k];
            m_rel_ev[k]   = all_diff & ~m_stb[k];
            if (all_diff) m_stb[k] = ~m_stb[k];
        end
        m_hist.push_front(raw);
        while (m_hist.size() > DEB + 2) void'(m_hist.pop_back());
    endtask

    // ------------------------------------------------ driver / sampler
    int rel = 0;
    int fre_q[$];
    int pha_q[$];

    task automatic tick();
        @(posedge sys_clk);
        if (sys_rst) model_reset();
        else         model_edge(key_in);
        @(negedge sys_clk);
        rel++;
        check("mode_model", mode_key, m_mode);
        check("fre_model", fre_adjust, m_pulse[0]);
        check("pha_model", pha_adjust, m_pulse[1]);
        if (fre_adjust === 1'b1) fre_q.push_back(rel);
        if (pha_adjust === 1'b1) pha_q.push_back(rel);
    endtask

    task automatic start_seq();
        rel = 0;
        fre_q.delete();
        pha_q.delete();
    endtask

    task automatic do_reset(input int n);
        sys_rst = 1'b1;
        model_reset();
        #1;
        check("rst_mode", mode_key, 2'b01);
        check("rst_fre", fre_adjust, 1'b0);
        check("rst_pha", pha_adjust, 1'b0);
        check("rst_stb", dbg.stb, 3'b111);
        check("rst_fre_state", dbg.fre_state, IDLE);
        check("rst_pha_state", dbg.pha_state, IDLE);
        @(negedge sys_clk);
        repeat (n) tick();
        sys_rst = 1'b0;
        start_seq();
    endtask

    task automatic check_list(input string name, input bit use_pha, input int n, input int exp[8]);
        int q[$];
        if (use_pha) q = pha_q;
        else         q = fre_q;
        check({name, "_count"}, q.size(), n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_t%0d", name, i), (i < q.size()) ? q[i] : -1, exp[i]);
        end
    endtask

    // ------------------------------------------------ table vectors
    typedef struct {
        logic [2:0] keys;   // raw pattern while pressed
        int         hold;   // raw press length in cycles
        int         gap;    // released cycles afterwards
        logic [1:0] exp_mode;
        int         exp_fre;
        int         exp_pha;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int mode_exp [4];
        int kh [3];
        logic [1:0] prev_mode;
        int seen;

        vecs[0] = '{3'b110,  5, 12, 2'd2, 0, 0};
        vecs[1] = '{3'b101,  3, 12, 2'd2, 0, 0};
        vecs[2] = '{3'b101,  4, 12, 2'd2, 1, 0};
        vecs[3] = '{3'b011, 11, 12, 2'd2, 0, 2};
        vecs[4] = '{3'b001, 16, 12, 2'd2, 3, 3};
        vecs[5] = '{3'b000, 10, 12, 2'd3, 1, 1};
        vecs[6] = '{3'b110,  3, 12, 2'd3, 0, 0};
        vecs[7] = '{3'b010,  4, 12, 2'd0, 0, 1};
        vecs[8] = '{3'b100, 20, 12, 2'd1, 3, 0};
        vecs[9] = '{3'b110,  6, 12, 2'd2, 0, 0};
        mode_exp = '{2, 3, 0, 1};

        @(negedge sys_clk);
        do_reset(3);

        // four clean mode presses, each update 7 cycles after the raw edge
        for (int p = 0; p < 4; p++) begin
            start_seq();
            prev_mode = mode_key;
            seen = -1;
            key_in[0] = 1'b0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (seen < 0 && mode_key !== prev_mode) seen = rel;
            end
            check($sformatf("mode_lat%0d", p), seen, 7);
            check($sformatf("mode_val%0d", p), mode_key, mode_exp[p]);
            key_in[0] = 1'b1;
            repeat (12) tick();
        end

        // bouncing mode key: no event, mode unchanged
        start_seq();
        for (int c = 0; c < 20; c++) begin
            key_in[0] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
        end
        key_in[0] = 1'b1;
        repeat (10) tick();
        check("bounce_mode", mode_key, 2'b01);
        check("bounce_stb", dbg.stb[0], 1'b1);
        check("bounce_pulses", fre_q.size() + pha_q.size(), 0);

        // freq held: pulse schedule, then nothing after release
        start_seq();
        key_in[1] = 1'b0;
        repeat (35) tick();
        key_in[1] = 1'b1;
        repeat (25) tick();
        check_list("fre_hold", 1'b0, 6, '{7, 17, 22, 27, 32, 37, 0, 0});
        check("fre_hold_pha", pha_q.size(), 0);

        // all three keys on the same cycle
        start_seq();
        key_in = 3'b000;
        repeat (7) tick();
        check("sim_fre", fre_adjust, 1'b1);
        check("sim_pha", pha_adjust, 1'b1);
        check("sim_mode", mode_key, 2'b10);
        tick();
        key_in = 3'b111;
        repeat (20) tick();
        check_list("sim_fre", 1'b0, 1, '{7, 0, 0, 0, 0, 0, 0, 0});
        check_list("sim_pha", 1'b1, 1, '{7, 0, 0, 0, 0, 0, 0, 0});

        // phase release lands on the HOLD expiry cycle
        start_seq();
        key_in[2] = 1'b0;
        repeat (10) tick();
        key_in[2] = 1'b1;
        repeat (7) tick();
        check("pha_rel_pulse", pha_adjust, 1'b0);
        check("pha_rel_state", dbg.pha_state, IDLE);
        repeat (10) tick();
        check_list("pha_rel", 1'b1, 1, '{7, 0, 0, 0, 0, 0, 0, 0});

        // reset in the middle of auto-repeat with the freq key held
        start_seq();
        key_in[1] = 1'b0;
        repeat (24) tick();
        check_list("pre_rst", 1'b0, 3, '{7, 17, 22, 0, 0, 0, 0, 0});
        do_reset(3);
        repeat (12) tick();
        check_list("post_rst", 1'b0, 1, '{7, 0, 0, 0, 0, 0, 0, 0});
        key_in[1] = 1'b1;
        repeat (15) tick();

        // table vectors from a fresh reset
        do_reset(2);
        for (int v = 0; v < 10; v++) begin
            start_seq();
            key_in = vecs[v].keys;
            repeat (vecs[v].hold) tick();
            key_in = 3'b111;
            repeat (vecs[v].gap) tick();
            check($sformatf("vec%0d_mode", v), mode_key, vecs[v].exp_mode);
            check($sformatf("vec%0d_fre", v), fre_q.size(), vecs[v].exp_fre);
            check($sformatf("vec%0d_pha", v), pha_q.size(), vecs[v].exp_pha);
        end

        // random key activity against the model, with one reset inside
        do_reset(2);
        for (int k = 0; k < 3; k++) kh[k] = $urandom_range(1, 25);
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) do_reset(2);
            for (int k = 0; k < 3; k++) begin
                if (kh[k] == 0) begin
                    key_in[k] = ~key_in[k];
                    kh[k] = $urandom_range(1, 25);
                end else begin
                    kh[k]--;
                end
            end
            tick();
        end
        key_in = 3'b111;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
